// File: rtl/vmask_popc_seq_pkg.sv
// vmask_popc_seq_pkg
//   Shared definitions for the mask sequencers (vcpop.m, vfirst.m, vmsbf.m):
//   - vseq_state_e : sequencer state encoding (IDLE/ISSUE/DRAIN/WAIT/WB)
//   - tail_keep()  : per-bit tail-mask rule for a W-bit mask beat
package vmask_popc_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        DRAIN,
        WAIT,
        WB
    } vseq_state_e;

    // Bit idx of a beat survives unless this is the final beat of a partial
    // operation (rem != 0) and idx lies at or beyond rem.
    function automatic logic tail_keep(input int unsigned idx,
                                       input int unsigned rem,
                                       input logic        last);
        return !last || (rem == 0) || (idx < rem);
    endfunction

endpackage

// File: rtl/vmask_popc_seq_if.sv
// vmask_popc_seq_if
//   Bus bundle of the vcpop.m sequencer: command, VRF read request/response,
//   popc datapath beat/result and write-back handshake.
//   master : the sequencer side
//   slave  : the environment side (command source, VRF, popc unit, WB sink)
interface vmask_popc_seq_if #(
    parameter int unsigned REQ_DATA_WIDTH  = 64,
    parameter int unsigned RESP_DATA_WIDTH = 64,
    parameter int unsigned REQ_ADDR_WIDTH  = 32,
    parameter int unsigned VL_WIDTH        = 16
);
    logic                       cmd_valid;
    logic                       cmd_ready;
    logic [REQ_ADDR_WIDTH-1:0]  cmd_vs_addr;
    logic [REQ_ADDR_WIDTH-1:0]  cmd_vd_addr;
    logic [VL_WIDTH-1:0]        cmd_vl;

    logic                       rd_req_valid;
    logic                       rd_req_ready;
    logic [REQ_ADDR_WIDTH-1:0]  rd_req_addr;
    logic                       rd_rsp_valid;
    logic [REQ_DATA_WIDTH-1:0]  rd_rsp_data;

    logic                       popc_valid;
    logic [REQ_DATA_WIDTH-1:0]  popc_m0;
    logic                       popc_end;
    logic [REQ_ADDR_WIDTH-1:0]  popc_addr;
    logic                       popc_out_valid;
    logic [RESP_DATA_WIDTH-1:0] popc_out_vec;

    logic                       wb_valid;
    logic                       wb_ready;
    logic [RESP_DATA_WIDTH-1:0] wb_data;
    logic [REQ_ADDR_WIDTH-1:0]  wb_addr;

    modport master (
        input  cmd_valid, cmd_vs_addr, cmd_vd_addr, cmd_vl,
        output cmd_ready,
        output rd_req_valid, rd_req_addr,
        input  rd_req_ready, rd_rsp_valid, rd_rsp_data,
        output popc_valid, popc_m0, popc_end, popc_addr,
        input  popc_out_valid, popc_out_vec,
        output wb_valid, wb_data, wb_addr,
        input  wb_ready
    );

    modport slave (
        output cmd_valid, cmd_vs_addr, cmd_vd_addr, cmd_vl,
        input  cmd_ready,
        input  rd_req_valid, rd_req_addr,
        output rd_req_ready, rd_rsp_valid, rd_rsp_data,
        input  popc_valid, popc_m0, popc_end, popc_addr,
        output popc_out_valid, popc_out_vec,
        input  wb_valid, wb_data, wb_addr,
        output wb_ready
    );

endinterface

// File: rtl/vmask_tail.sv
// vmask_tail
//   Combinational tail mask for one W-bit mask beat.
//   rem  : vl mod W
//   last : beat is the final beat of the operation
//   mask : all ones, or (1<<rem)-1 when last && rem != 0
module vmask_tail #(
    parameter int unsigned W = 64
) (
    input  logic [$clog2(W)-1:0] rem,
    input  logic                 last,
    output logic [W-1:0]         mask
);
    import vmask_popc_seq_pkg::*;

    always_comb begin
        mask = '0;
        for (int unsigned i = 0; i < W; i++) begin
            mask[i] = tail_keep(i, 32'(rem), last);
        end
    end

endmodule

// File: rtl/vmask_popc_seq.sv
// vmask_popc_seq
//   vcpop.m sequencer: accepts one command, issues ceil(vl/W) VRF mask-beat
//   reads (at most MAX_OUT outstanding), streams tail-masked beats into the
//   popc datapath, captures the popc result and offers it for write-back.
//   Ports:
//     clk  : clock
//     rst  : asynchronous active-low reset
//     bus  : command / VRF read / popc / write-back bundle (master side)
//     busy : high whenever an operation is in progress
module vmask_popc_seq #(
    parameter int unsigned REQ_DATA_WIDTH  = 64,
    parameter int unsigned RESP_DATA_WIDTH = 64,
    parameter int unsigned REQ_ADDR_WIDTH  = 32,
    parameter int unsigned VL_WIDTH        = 16,
    parameter int unsigned MAX_OUT         = 4,
    parameter int unsigned ADDR_STRIDE     = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    vmask_popc_seq_if.master        bus,
    output logic                    busy
);
    import vmask_popc_seq_pkg::*;

    localparam int unsigned LOG2W = $clog2(REQ_DATA_WIDTH);
    // One extra bit so the beat count for vl = all-ones cannot overflow.
    localparam int unsigned CNT_W = VL_WIDTH + 1;

    vseq_state_e                state_q, state_d;
    logic [REQ_ADDR_WIDTH-1:0]  vs_q, vd_q;
    logic [CNT_W-1:0]           n_q, iss_cnt, rsp_cnt, outst;
    logic [LOG2W-1:0]           rem_q;
    logic [RESP_DATA_WIDTH-1:0] res_q;
    logic [REQ_DATA_WIDTH-1:0]  tail_mask;
    logic                       cmd_fire, req_fire, rsp_fire, beat_last;

    assign outst     = iss_cnt - rsp_cnt;
    assign cmd_fire  = (state_q == IDLE) && bus.cmd_valid;
    assign req_fire  = bus.rd_req_valid && bus.rd_req_ready;
    // Responses are only meaningful while this operation owns the VRF reads;
    // stragglers from an aborted operation land in IDLE and are dropped.
    assign rsp_fire  = bus.rd_rsp_valid && ((state_q == ISSUE) || (state_q == DRAIN));
    assign beat_last = (rsp_cnt == (n_q - CNT_W'(1)));

    vmask_tail #(
        .W (REQ_DATA_WIDTH)
    ) u_tail (
        .rem  (rem_q),
        .last (beat_last),
        .mask (tail_mask)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        busy             = 1'b1;
        bus.cmd_ready    = 1'b0;
        bus.rd_req_valid = 1'b0;
        bus.rd_req_addr  = '0;
        bus.wb_valid     = 1'b0;
        bus.wb_data      = '0;
        bus.wb_addr      = '0;
        case (state_q)
            IDLE: begin
                busy          = 1'b0;
                bus.cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    state_d = (bus.cmd_vl == '0) ? WB : ISSUE;
                end
            end
            ISSUE: begin
                bus.rd_req_valid = (iss_cnt < n_q) && (outst < CNT_W'(MAX_OUT));
                bus.rd_req_addr  = vs_q + REQ_ADDR_WIDTH'(iss_cnt) * REQ_ADDR_WIDTH'(ADDR_STRIDE);
                if (iss_cnt == n_q) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (rsp_cnt == n_q) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (bus.popc_out_valid) begin
                    state_d = WB;
                end
            end
            WB: begin
                bus.wb_valid = 1'b1;
                bus.wb_data  = res_q;
                bus.wb_addr  = vd_q;
                if (bus.wb_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vs_q           <= '0;
            vd_q           <= '0;
            n_q            <= '0;
            rem_q          <= '0;
            iss_cnt        <= '0;
            rsp_cnt        <= '0;
            res_q          <= '0;
            bus.popc_valid <= 1'b0;
            bus.popc_m0    <= '0;
            bus.popc_end   <= 1'b0;
            bus.popc_addr  <= '0;
        end else begin
            if (cmd_fire) begin
                vs_q    <= bus.cmd_vs_addr;
                vd_q    <= bus.cmd_vd_addr;
                // ceil(vl/W) without widening the addition
                n_q     <= CNT_W'(bus.cmd_vl >> LOG2W) + CNT_W'(|bus.cmd_vl[LOG2W-1:0]);
                rem_q   <= bus.cmd_vl[LOG2W-1:0];
                iss_cnt <= '0;
                rsp_cnt <= '0;
                res_q   <= '0;
            end else begin
                if (req_fire) begin
                    iss_cnt <= iss_cnt + CNT_W'(1);
                end
                if (rsp_fire) begin
                    rsp_cnt <= rsp_cnt + CNT_W'(1);
                end
                if ((state_q == WAIT) && bus.popc_out_valid) begin
                    res_q <= bus.popc_out_vec;
                end
            end
            bus.popc_valid <= rsp_fire;
            bus.popc_m0    <= rsp_fire ? (bus.rd_rsp_data & tail_mask) : '0;
            bus.popc_end   <= rsp_fire && beat_last;
            bus.popc_addr  <= rsp_fire ? vd_q : '0;
        end
    end

endmodule

// File: tb/tb_vmask_popc_seq.sv
// tb_vmask_popc_seq
//   Directed bench for vmask_popc_seq with a VRF responder (fixed latency,
//   optional toggling ready) and a popc unit that returns the accumulated
//   count two cycles after the end beat.
module tb_vmask_popc_seq;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic busy;

    always #5 clk = ~clk;

    vmask_popc_seq_if #(
        .REQ_DATA_WIDTH  (64),
        .RESP_DATA_WIDTH (64),
        .REQ_ADDR_WIDTH  (32),
        .VL_WIDTH        (16)
    ) bus ();

    vmask_popc_seq #(
        .REQ_DATA_WIDTH  (64),
        .RESP_DATA_WIDTH (64),
        .REQ_ADDR_WIDTH  (32),
        .VL_WIDTH        (16),
        .MAX_OUT         (4),
        .ADDR_STRIDE     (1)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    int          n_pass = 0;
    int          n_chk  = 0;
    int          lat          = 2;
    bit          ready_toggle = 1'b0;
    logic [63:0] rsp_pattern  = '1;

    logic [31:0] req_log[$];
    logic [63:0] beat_m0[$];
    logic        beat_end[$];
    logic [31:0] beat_addr[$];
    int          acc_total = 0;
    int          rsp_total = 0;
    int          max_out   = 0;
    int          junk      = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // VRF model: logs accepted requests, answers in order after lat cycles.
    initial begin : vrf_model
        int     cyc = 0;
        int     due_q[$];
        bit     hs, rv;
        logic [31:0] ha;
        bus.rd_req_ready = 1'b1;
        bus.rd_rsp_valid = 1'b0;
        bus.rd_rsp_data  = '0;
        forever begin
            @(negedge clk);
            hs = bus.rd_req_valid && bus.rd_req_ready;
            ha = bus.rd_req_addr;
            rv = bus.rd_rsp_valid;
            @(posedge clk);
            #1;
            cyc++;
            if (rv) rsp_total++;
            if (hs) begin
                acc_total++;
                req_log.push_back(ha);
                due_q.push_back(cyc + lat - 1);
            end
            if (acc_total - rsp_total > max_out) max_out = acc_total - rsp_total;
            if (due_q.size() > 0 && due_q[0] <= cyc) begin
                bus.rd_rsp_valid = 1'b1;
                bus.rd_rsp_data  = rsp_pattern;
                void'(due_q.pop_front());
            end else begin
                bus.rd_rsp_valid = 1'b0;
                bus.rd_rsp_data  = '0;
            end
            bus.rd_req_ready = ready_toggle ? ((cyc % 2) == 1) : 1'b1;
        end
    end

    // popc unit model: accumulate beats, pulse the sum 2 cycles after end.
    initial begin : popc_model
        logic [63:0] acc = '0;
        logic [63:0] res = '0;
        int          pend = 0;
        bus.popc_out_valid = 1'b0;
        bus.popc_out_vec   = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                acc  = '0;
                pend = 0;
            end else if (bus.popc_valid) begin
                beat_m0.push_back(bus.popc_m0);
                beat_end.push_back(bus.popc_end);
                beat_addr.push_back(bus.popc_addr);
                acc = acc + 64'($countones(bus.popc_m0));
                if (bus.popc_end) begin
                    res  = acc;
                    acc  = '0;
                    pend = 2;
                end
            end
            if (!bus.popc_valid && (bus.popc_m0 != '0 || bus.popc_end || bus.popc_addr != '0))
                junk++;
            @(posedge clk);
            #1;
            bus.popc_out_valid = 1'b0;
            bus.popc_out_vec   = '0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    bus.popc_out_valid = 1'b1;
                    bus.popc_out_vec   = res;
                end
            end
        end
    end

    task automatic clear_logs();
        @(posedge clk);
        #3;
        req_log.delete();
        beat_m0.delete();
        beat_end.delete();
        beat_addr.delete();
        max_out = 0;
        junk    = 0;
    endtask

    task automatic send_cmd(input logic [31:0] vs, input logic [31:0] vd,
                            input logic [15:0] vl, output time t_acc);
        bit got = 1'b0;
        @(posedge clk);
        #1;
        bus.cmd_vs_addr = vs;
        bus.cmd_vd_addr = vd;
        bus.cmd_vl      = vl;
        bus.cmd_valid   = 1'b1;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (bus.cmd_ready) got = 1'b1;
        end
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        t_acc = $time;
        if (!got) chk("cmd_accept_timeout", 64'(got), 64'd1);
    endtask

    task automatic wait_wb(input string tag, output time t_wb);
        bit got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            if (bus.wb_valid) got = 1'b1;
        end
        t_wb = $time;
        chk(tag, 64'(got), 64'd1);
    endtask

    task automatic wb_handshake();
        @(posedge clk);
        #1;
        bus.wb_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.wb_ready = 1'b0;
    endtask

    initial begin : stimulus
        time t_acc, t_wb;
        int  unstable, ends;
        bit  got;

        bus.cmd_valid   = 1'b0;
        bus.cmd_vs_addr = '0;
        bus.cmd_vd_addr = '0;
        bus.cmd_vl      = '0;
        bus.wb_ready    = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready",    64'(bus.cmd_ready),    64'd1);
        chk("rst_busy",         64'(busy),             64'd0);
        chk("rst_rd_req_valid", 64'(bus.rd_req_valid), 64'd0);
        chk("rst_popc_valid",   64'(bus.popc_valid),   64'd0);
        chk("rst_wb_valid",     64'(bus.wb_valid),     64'd0);
        chk("rst_wb_data",      bus.wb_data,           64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // 1: single full beat
        lat = 2; ready_toggle = 1'b0; rsp_pattern = '1;
        clear_logs();
        send_cmd(32'h10, 32'h5, 16'd64, t_acc);
        wait_wb("t1_wb_seen", t_wb);
        chk("t1_nreq",    64'(req_log.size()), 64'd1);
        chk("t1_addr0",   64'(req_log[0]),     64'h10);
        chk("t1_nbeats",  64'(beat_m0.size()), 64'd1);
        chk("t1_m0",      beat_m0[0],          64'hFFFF_FFFF_FFFF_FFFF);
        chk("t1_end",     64'(beat_end[0]),    64'd1);
        chk("t1_paddr",   64'(beat_addr[0]),   64'h5);
        chk("t1_wb_data", bus.wb_data,         64'd64);
        chk("t1_wb_addr", 64'(bus.wb_addr),    64'h5);
        wb_handshake();

        // 2: partial tail beat
        clear_logs();
        send_cmd(32'h20, 32'h7, 16'd100, t_acc);
        wait_wb("t2_wb_seen", t_wb);
        chk("t2_nreq",    64'(req_log.size()), 64'd2);
        chk("t2_addr0",   64'(req_log[0]),     64'h20);
        chk("t2_addr1",   64'(req_log[1]),     64'h21);
        chk("t2_end0",    64'(beat_end[0]),    64'd0);
        chk("t2_m0_1",    beat_m0[1],          64'h0000_000F_FFFF_FFFF);
        chk("t2_end1",    64'(beat_end[1]),    64'd1);
        chk("t2_wb_data", bus.wb_data,         64'd100);
        wb_handshake();

        // 3: vl = 0
        clear_logs();
        send_cmd(32'h30, 32'h9, 16'd0, t_acc);
        wait_wb("t3_wb_seen", t_wb);
        chk("t3_wb_latency", 64'((t_wb - t_acc) <= 24), 64'd1);
        chk("t3_nreq",    64'(req_log.size()), 64'd0);
        chk("t3_nbeats",  64'(beat_m0.size()), 64'd0);
        chk("t3_wb_data", bus.wb_data,         64'd0);
        chk("t3_wb_addr", 64'(bus.wb_addr),    64'h9);
        wb_handshake();

        // 4: 8 beats, toggling ready, latency 5
        lat = 5; ready_toggle = 1'b1; rsp_pattern = 64'h0F0F_0F0F_0F0F_0F0F;
        clear_logs();
        send_cmd(32'h100, 32'h3, 16'd512, t_acc);
        wait_wb("t4_wb_seen", t_wb);
        chk("t4_nreq", 64'(req_log.size()), 64'd8);
        for (int i = 0; i < 8; i++)
            chk($sformatf("t4_addr%0d", i), 64'(req_log[i]), 64'(32'h100 + i));
        chk("t4_max_out_le4", 64'(max_out <= 4), 64'd1);
        chk("t4_nbeats", 64'(beat_m0.size()), 64'd8);
        ends = 0;
        foreach (beat_end[i]) ends += int'(beat_end[i]);
        chk("t4_end_count", 64'(ends),        64'd1);
        chk("t4_end7",      64'(beat_end[7]), 64'd1);
        chk("t4_m0_7",      beat_m0[7],       64'h0F0F_0F0F_0F0F_0F0F);
        chk("t4_wb_data",   bus.wb_data,      64'd256);
        wb_handshake();

        // 4b: ready held high, long latency: window fills to exactly 4
        lat = 8; ready_toggle = 1'b0; rsp_pattern = '1;
        clear_logs();
        send_cmd(32'h180, 32'h4, 16'd512, t_acc);
        wait_wb("t4b_wb_seen", t_wb);
        chk("t4b_max_out",  64'(max_out),  64'd4);
        chk("t4b_wb_data",  bus.wb_data,   64'd512);
        chk("t4b_junk",     64'(junk),     64'd0);
        wb_handshake();

        // 5: write-back backpressure with a pending command
        lat = 2;
        clear_logs();
        send_cmd(32'h40, 32'hA, 16'd64, t_acc);
        wait_wb("t5_wb_seen", t_wb);
        @(posedge clk);
        #1;
        bus.cmd_vs_addr = 32'h50;
        bus.cmd_vd_addr = 32'hB;
        bus.cmd_vl      = 16'd64;
        bus.cmd_valid   = 1'b1;
        unstable = 0;
        repeat (10) begin
            @(negedge clk);
            if (!(bus.wb_valid === 1'b1 && bus.wb_data === 64'd64 &&
                  bus.wb_addr === 32'hA && bus.cmd_ready === 1'b0)) unstable++;
        end
        chk("t5_wb_stable", 64'(unstable),       64'd0);
        chk("t5_no_issue",  64'(req_log.size()), 64'd1);
        @(posedge clk);
        #1;
        bus.wb_ready = 1'b1;
        @(negedge clk);
        chk("t5_cmd_ready_pre_hs", 64'(bus.cmd_ready), 64'd0);
        @(posedge clk);
        #1;
        bus.wb_ready = 1'b0;
        @(negedge clk);
        chk("t5_cmd_ready_post_hs", 64'(bus.cmd_ready), 64'd1);
        chk("t5_wb_valid_post_hs",  64'(bus.wb_valid),  64'd0);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        chk("t5_busy_after_accept", 64'(busy), 64'd1);
        wait_wb("t5_wb2_seen", t_wb);
        chk("t5_wb2_data", bus.wb_data,       64'd64);
        chk("t5_wb2_addr", 64'(bus.wb_addr),  64'hB);
        chk("t5_addr1",    64'(req_log[1]),   64'h50);
        wb_handshake();

        // 6: reset mid-ISSUE, then a clean operation
        lat = 8;
        clear_logs();
        send_cmd(32'h200, 32'hC, 16'd512, t_acc);
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (req_log.size() >= 3) got = 1'b1;
        end
        chk("t6_three_reads", 64'(got), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("t6_rst_busy",         64'(busy),             64'd0);
        chk("t6_rst_cmd_ready",    64'(bus.cmd_ready),    64'd1);
        chk("t6_rst_rd_req_valid", 64'(bus.rd_req_valid), 64'd0);
        chk("t6_rst_wb_valid",     64'(bus.wb_valid),     64'd0);
        chk("t6_rst_popc_valid",   64'(bus.popc_valid),   64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        clear_logs();
        repeat (20) @(negedge clk);
        chk("t6_stale_beats", 64'(beat_m0.size()), 64'd0);
        chk("t6_stale_reqs",  64'(req_log.size()), 64'd0);
        chk("t6_idle_wb",     64'(bus.wb_valid),   64'd0);
        lat = 2;
        clear_logs();
        send_cmd(32'h300, 32'hD, 16'd64, t_acc);
        wait_wb("t6_wb_seen", t_wb);
        chk("t6_wb_data", bus.wb_data,      64'd64);
        chk("t6_wb_addr", 64'(bus.wb_addr), 64'hD);
        chk("t6_junk",    64'(junk),        64'd0);
        wb_handshake();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
